sample_resp_capture: RTL and testbench

Downstream capture stage for the generated `sample` netlist: registers its `o`/`p`/`q` responses during a run window and compacts every valid response into an 8-bit MISR signature. It counts the samples and buffers them in a small FIFO for a valid/ready consumer. It converts the purely combinational netlist output into a checkable, flow-controlled sample stream plus a run summary.

---
 rtl/sample_cap_pkg.sv | 25 ++
 rtl/sample_cap_fifo.sv | 61 ++++++
 rtl/sample_resp_capture.sv | 126 ++++++++++++
 tb/tb_sample_resp_capture.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_cap_pkg.sv
// Shared types and constants for the sample response capture stage.
// Also holds the MISR update step used by the top.
package sample_cap_pkg;

    localparam int SAMPLE_W = 3;
    localparam int MISR_W   = 8;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One MISR step: Galois shift with feedback, then fold the sample into the low bits.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0]   i_sig,
        input logic [SAMPLE_W-1:0] i_sample
    );
        logic [MISR_W-1:0] w_shifted;
        w_shifted = {i_sig[MISR_W-2:0], 1'b0} ^ (i_sig[MISR_W-1] ? MISR_POLY : '0);
        return w_shifted ^ {{(MISR_W-SAMPLE_W){1'b0}}, i_sample};
    endfunction

endpackage

// File: rtl/sample_cap_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sample_cap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // When full, a push is still taken if the head leaves on the same edge;
    // the write then lands in the slot being vacated.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/sample_resp_capture.sv
// Capture stage for the sample netlist: run-window FSM, MISR signature,
// saturating sample counter and a buffered valid/ready sample stream.
module sample_resp_capture
    import sample_cap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                in_valid,
    input  logic                in_o,
    input  logic                in_p,
    input  logic                in_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic [MISR_W-1:0]   sig,
    output logic [CNT_W-1:0]    count,
    output logic                overflow,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    state_t              r_state;
    logic [MISR_W-1:0]   r_sig;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_busy;
    logic                r_done;

    logic [SAMPLE_W-1:0] w_sample;
    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [SAMPLE_W-1:0] w_head;

    assign w_sample = {in_o, in_p, in_q};
    assign w_accept = (r_state == RUN) && in_valid;

    // Output handshake: a transfer happens on a rising edge where out_valid and
    // out_ready are both high; out_data stays put until that edge.
    assign w_pop  = out_ready && !w_empty;
    assign w_push = w_accept && (!w_full || w_pop);
    assign w_drop = w_accept && w_full && !w_pop;

    sample_cap_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_sample),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sig      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_sig      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    // A sample arriving with stop is still part of the run.
                    if (w_accept) begin
                        r_sig <= misr_next(r_sig, w_sample);
                        if (r_count != '1) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (stop) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_head;
    assign sig       = r_sig;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sample_resp_capture.sv
// Randomized and directed bench for sample_resp_capture with a queue-based
// reference model and a decoupled output monitor.
module tb_sample_resp_capture;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_o = 1'b0;
    logic             in_p = 1'b0;
    logic             in_q = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [2:0]       out_data;
    logic [7:0]       sig;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    sample_resp_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_o      (in_o),
        .in_p      (in_p),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sig       (sig),
        .count     (count),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: run mode, buffered samples, signature, count, flags.
    int               m_state = M_IDLE;
    logic [7:0]       m_sig   = '0;
    logic [CNT_W-1:0] m_count = '0;
    bit               m_ovf   = 1'b0;
    bit               m_done  = 1'b0;
    logic [2:0]       m_fifo[$];
    logic [2:0]       exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x modulo x^8+x^4+x^3+x^2+1, add sample.
    function automatic logic [7:0] ref_misr(input logic [7:0] s0, input logic [2:0] smp);
        int t;
        t = int'(s0) * 2;
        if (t >= 256) t = t ^ 'h11D;
        t = t ^ int'(smp);
        return 8'(t);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_sig   = '0;
        m_count = '0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        m_fifo.delete();
        exp_q.delete();
    endtask

    task automatic model_step();
        int         occ;
        bit         do_pop;
        logic [2:0] s;
        s      = {in_o, in_p, in_q};
        occ    = m_fifo.size();
        do_pop = (occ > 0) && out_ready;
        m_done = 1'b0;
        if (do_pop) void'(m_fifo.pop_front());
        case (m_state)
            M_IDLE: begin
                if (start) begin
                    m_state = M_RUN;
                    m_sig   = '0;
                    m_count = '0;
                    m_ovf   = 1'b0;
                end
            end
            M_RUN: begin
                if (in_valid) begin
                    m_sig = ref_misr(m_sig, s);
                    if (m_count != {CNT_W{1'b1}}) m_count = m_count + 1'b1;
                    if (occ < DEPTH || do_pop) begin
                        m_fifo.push_back(s);
                        exp_q.push_back(s);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (stop) m_state = M_DRAIN;
            end
            default: begin
                if (occ == 0) begin
                    m_state = M_IDLE;
                    m_done  = 1'b1;
                end
            end
        endcase
    endtask

    task automatic cycle(input bit st, input bit sp, input bit v, input logic [2:0] s, input bit rdy);
        start     = st;
        stop      = sp;
        in_valid  = v;
        {in_o, in_p, in_q} = s;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sig", sig, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain_run(input bit toggle_ready);
        int budget;
        bit rdy;
        rdy = 1'b1;
        cycle(0, 1, 0, 3'd0, rdy);
        budget = 0;
        while (busy && budget < 40) begin
            if (toggle_ready) rdy = ~rdy;
            cycle(0, 0, 0, 3'd0, rdy);
            budget++;
        end
        check("drain_timeout_busy", busy, 0);
        cycle(0, 0, 0, 3'd0, 1);
    endtask

    // Status checker: compare registered outputs to the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy", busy, (m_state != M_IDLE) ? 1 : 0);
                check("done", done, m_done);
                check("sig", sig, m_sig);
                check("count", count, m_count);
                check("overflow", overflow, m_ovf);
                check("out_valid", out_valid, (m_fifo.size() != 0) ? 1 : 0);
            end
        end
    end

    // Output monitor: every handshake pops the scoreboard and compares data.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got %0h expected none at %0t", out_data, $time);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [2:0] r;
        apply_reset();

        // Basic run: two samples streamed straight through.
        cycle(1, 0, 0, 3'd0, 1);
        cycle(0, 0, 1, 3'b101, 1);
        check("t1_sig0", sig, 8'h05);
        check("t1_data0", out_data, 3'd5);
        cycle(0, 0, 1, 3'b111, 1);
        check("t1_sig1", sig, 8'h0D);
        check("t1_count", count, 2);
        check("t1_data1", out_data, 3'd7);
        drain_run(0);

        // Overflow: six samples into a four-deep buffer with no consumer.
        cycle(1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 3'($urandom_range(0, 7)), 0);
        check("t2_overflow", overflow, 1);
        check("t2_count", count, 6);
        drain_run(0);
        check("t2_sb_empty", exp_q.size(), 0);

        // Full buffer with a simultaneous push and pop: nothing dropped.
        cycle(1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 3'($urandom_range(0, 7)), 0);
        cycle(0, 0, 1, 3'($urandom_range(0, 7)), 1);
        check("t3_no_overflow", overflow, 0);
        drain_run(0);

        // Stop with three held entries and a stuttering consumer.
        cycle(1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3'($urandom_range(0, 7)), 0);
        drain_run(1);

        // Ignored controls: in_valid in IDLE, start+stop in IDLE, start in RUN, activity in DRAIN.
        cycle(0, 0, 1, 3'd3, 1);
        cycle(0, 1, 1, 3'd2, 1);
        cycle(1, 1, 1, 3'd6, 1);
        cycle(1, 0, 1, 3'd2, 1);
        cycle(0, 1, 1, 3'd4, 0);
        cycle(1, 1, 1, 3'd1, 0);
        check("t5_count", count, 2);
        drain_run(0);

        // Reset in the middle of a run with two entries held.
        cycle(1, 0, 0, 3'd0, 0);
        cycle(0, 0, 1, 3'd6, 0);
        cycle(0, 0, 1, 3'd1, 0);
        apply_reset();
        cycle(1, 0, 0, 3'd0, 0);
        cycle(0, 0, 1, 3'd2, 0);
        cycle(0, 0, 1, 3'd3, 1);
        drain_run(0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = 3'($urandom_range(0, 7));
            cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 1)));
        end
        drain_run(0);
        check("final_sb_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
